// File: rtl/spu_fx2_pkg.sv
// Shared definitions for the SPU FX2 shift/rotate pipe: opcodes, widths, stage record.
package spu_fx2_pkg;

    localparam int FX2_LAT = 4;
    localparam int WORD_W  = 32;
    localparam int HALF_W  = 16;
    localparam int DATA_W  = 128;
    localparam int RT_W    = 7;

    typedef enum logic [3:0] {
        OP_SHL   = 4'h0,
        OP_SHLI  = 4'h1,
        OP_ROT   = 4'h2,
        OP_ROTI  = 4'h3,
        OP_SHLH  = 4'h4,
        OP_SHLHI = 4'h5
    } fx2_op_e;

    typedef struct packed {
        logic              valid;
        logic [RT_W-1:0]   rt;
        logic [0:DATA_W-1] data;
        logic              err;
    } stage_t;

endpackage

// File: rtl/fx2_shift_core.sv
// Combinational FX2 datapath: per-word shift/rotate and per-halfword shift.
module fx2_shift_core
    import spu_fx2_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [0:DATA_W-1] ra,
    input  logic [0:DATA_W-1] rb,
    input  logic [0:6]        imm7,
    output logic [0:DATA_W-1] data,
    output logic              err
);

    logic        legal;
    logic        imm_form;
    logic        rot_op;
    logic        half_op;
    logic [31:0] word;
    logic [63:0] rot64;
    logic [5:0]  wcnt;
    logic [15:0] half;
    logic [4:0]  hcnt;

    // Decode the opcode into form/kind flags; anything not decoded is illegal.
    always_comb begin
        legal    = 1'b1;
        imm_form = 1'b0;
        rot_op   = 1'b0;
        half_op  = 1'b0;
        case (op)
            OP_SHL:   ;
            OP_SHLI:  imm_form = 1'b1;
            OP_ROT:   rot_op = 1'b1;
            OP_ROTI:  begin rot_op = 1'b1; imm_form = 1'b1; end
            OP_SHLH:  half_op = 1'b1;
            OP_SHLHI: begin half_op = 1'b1; imm_form = 1'b1; end
            default:  legal = 1'b0;
        endcase
    end

    // Process each word or halfword slot independently; sign-extending imm7 only adds
    // copies of its top bit above bit 6, so masking keeps just its low count bits.
    always_comb begin
        data  = '0;
        err   = !legal;
        word  = '0;
        rot64 = '0;
        wcnt  = '0;
        half  = '0;
        hcnt  = '0;
        if (legal && !half_op) begin
            for (int i = 0; i < DATA_W / WORD_W; i++) begin
                word  = ra[i*WORD_W +: WORD_W];
                wcnt  = imm_form ? imm7[1:6] : rb[i*WORD_W + WORD_W - 6 +: 6];
                rot64 = {word, word} << wcnt[4:0];
                if (rot_op)
                    data[i*WORD_W +: WORD_W] = rot64[63:32];
                else
                    data[i*WORD_W +: WORD_W] = (wcnt >= 6'd32) ? 32'd0 : (word << wcnt[4:0]);
            end
        end else if (legal) begin
            for (int i = 0; i < DATA_W / HALF_W; i++) begin
                half = ra[i*HALF_W +: HALF_W];
                hcnt = imm_form ? imm7[2:6] : rb[i*HALF_W + HALF_W - 5 +: 5];
                data[i*HALF_W +: HALF_W] = (hcnt >= 5'd16) ? 16'd0 : (half << hcnt[3:0]);
            end
        end
    end

endmodule

// File: rtl/fx2_pipe_ctrl.sv
// FX2 pipe control: issue handshake, LAT-deep result pipeline with stall/flush, hazard compare.
module fx2_pipe_ctrl
    import spu_fx2_pkg::*;
#(
    parameter int LAT = FX2_LAT
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        issue_op,
    input  logic [RT_W-1:0]   issue_rt,
    input  logic [0:DATA_W-1] issue_ra,
    input  logic [0:DATA_W-1] issue_rb,
    input  logic [0:6]        issue_imm7,
    input  logic              stall,
    input  logic              flush,
    input  logic [RT_W-1:0]   chk_a,
    input  logic [RT_W-1:0]   chk_b,
    output logic              hit_a,
    output logic              hit_b,
    output logic              wb_valid,
    output logic [RT_W-1:0]   wb_rt,
    output logic [0:DATA_W-1] wb_data,
    output logic              wb_err
);

    stage_t            stg [1:LAT];
    stage_t            issue_stage;
    logic              accept;
    logic [0:DATA_W-1] core_data;
    logic              core_err;

    fx2_shift_core u_core (
        .op   (issue_op),
        .ra   (issue_ra),
        .rb   (issue_rb),
        .imm7 (issue_imm7),
        .data (core_data),
        .err  (core_err)
    );

    assign issue_ready = !stall && !reset;
    assign accept      = issue_valid && issue_ready && !flush;

    // Package the freshly computed result as the next stage-1 entry.
    always_comb begin
        issue_stage       = '0;
        issue_stage.valid = accept;
        issue_stage.rt    = issue_rt;
        issue_stage.data  = core_data;
        issue_stage.err   = core_err;
    end

    // Stage registers: reset clears everything, flush kills valids, stall freezes the pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= LAT; k++)
                stg[k] <= '0;
        end else if (flush) begin
            for (int k = 1; k <= LAT; k++)
                stg[k].valid <= 1'b0;
        end else if (!stall) begin
            stg[1] <= issue_stage;
            for (int k = 2; k <= LAT; k++)
                stg[k] <= stg[k-1];
        end
    end

    // Hazard compare over valid stages ahead of writeback; writeback itself is forwarded.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            if (stg[k].valid && stg[k].rt == chk_a) hit_a = 1'b1;
            if (stg[k].valid && stg[k].rt == chk_b) hit_b = 1'b1;
        end
    end

    assign wb_valid = stg[LAT].valid;
    assign wb_rt    = stg[LAT].rt;
    assign wb_data  = stg[LAT].data;
    assign wb_err   = stg[LAT].err;

endmodule

// File: tb/tb_fx2_pipe_ctrl.sv
// Scoreboard bench for fx2_pipe_ctrl: directed ops, stall, flush, hazard and reset scenarios.
module tb_fx2_pipe_ctrl;
    import spu_fx2_pkg::*;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         issue_valid;
    logic         issue_ready;
    logic [3:0]   issue_op;
    logic [6:0]   issue_rt;
    logic [0:127] issue_ra;
    logic [0:127] issue_rb;
    logic [0:6]   issue_imm7;
    logic         stall;
    logic         flush;
    logic [6:0]   chk_a;
    logic [6:0]   chk_b;
    logic         hit_a;
    logic         hit_b;
    logic         wb_valid;
    logic [6:0]   wb_rt;
    logic [0:127] wb_data;
    logic         wb_err;

    typedef struct {
        logic [6:0]   rt;
        logic [127:0] data;
        logic         err;
        int           issue_cyc;
        int           stall_at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   stall_cnt = 0;
    bit   prev_hold = 1'b0;

    always #5 clk = ~clk;

    fx2_pipe_ctrl #(.LAT(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_rt    (issue_rt),
        .issue_ra    (issue_ra),
        .issue_rb    (issue_rb),
        .issue_imm7  (issue_imm7),
        .stall       (stall),
        .flush       (flush),
        .chk_a       (chk_a),
        .chk_b       (chk_b),
        .hit_a       (hit_a),
        .hit_b       (hit_b),
        .wb_valid    (wb_valid),
        .wb_rt       (wb_rt),
        .wb_data     (wb_data),
        .wb_err      (wb_err)
    );

    // Cycle counter: cycle N spans from the Nth rising edge to the next one.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one op for a cycle and record its expected writeback.
    task automatic applyStimulus(input logic [3:0] op, input logic [6:0] rt,
                                 input logic [127:0] ra, input logic [127:0] rb,
                                 input logic [6:0] imm, input logic [127:0] exp_data,
                                 input logic exp_err);
        exp_t e;
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rt    = rt;
        issue_ra    = ra;
        issue_rb    = rb;
        issue_imm7  = imm;
        e.rt        = rt;
        e.data      = exp_data;
        e.err       = exp_err;
        e.issue_cyc = cyc;
        e.stall_at  = stall_cnt;
        sb.push_back(e);
        nextCycle();
        issue_valid = 1'b0;
    endtask

    // Monitor: compare every presented writeback against the scoreboard head; pop when not stalled.
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (sb.size() == 0) begin
                checkOutput("wb_unexpected", {127'd0, wb_valid}, 128'd0);
            end else begin
                mon_e = sb[0];
                checkOutput("wb_rt", {121'd0, wb_rt}, {121'd0, mon_e.rt});
                checkOutput("wb_data", wb_data, mon_e.data);
                checkOutput("wb_err", {127'd0, wb_err}, {127'd0, mon_e.err});
                if (!prev_hold)
                    checkOutput("wb_latency", cyc, mon_e.issue_cyc + LAT + (stall_cnt - mon_e.stall_at));
                if (!stall) void'(sb.pop_front());
            end
        end
        prev_hold = wb_valid && stall && !reset;
        if (stall) stall_cnt++;
    end

    // Hard stop in case the stimulus ever wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_op    = '0;
        issue_rt    = '0;
        issue_ra    = '0;
        issue_rb    = '0;
        issue_imm7  = '0;
        stall       = 1'b0;
        flush       = 1'b0;
        chk_a       = 7'd0;
        chk_b       = 7'd0;

        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("rst_issue_ready", {127'd0, issue_ready}, 128'd0);
        checkOutput("rst_wb_valid", {127'd0, wb_valid}, 128'd0);
        checkOutput("rst_wb_err", {127'd0, wb_err}, 128'd0);
        checkOutput("rst_wb_rt", {121'd0, wb_rt}, 128'd0);
        checkOutput("rst_wb_data", wb_data, 128'd0);
        checkOutput("rst_hits", {126'd0, hit_a, hit_b}, 128'd0);
        nextCycle();
        reset = 1'b0;
        while (cyc < 10) nextCycle();

        // Directed vectors, issued back to back from cycle 10.
        applyStimulus(OP_SHLI, 7'd5, {32'h00000001, 32'h80000000, 32'h12345678, 32'hFFFFFFFF},
                      128'd0, 7'h04,
                      {32'h00000010, 32'h00000000, 32'h23456780, 32'hFFFFFFF0}, 1'b0);
        applyStimulus(OP_SHL, 7'd6, {4{32'hFFFFFFFF}},
                      {32'd32, 32'd0, 32'd31, 32'h00000041}, 7'h00,
                      {32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFE}, 1'b0);
        applyStimulus(OP_SHLHI, 7'd7, {4{32'h8001FFFF}}, 128'd0, 7'h7F, 128'd0, 1'b0);
        applyStimulus(OP_ROT, 7'd8, {32'h80000001, 32'h12345678, 32'hF0000000, 32'h00000001},
                      {32'd33, 32'd4, 32'd0, 32'd63}, 7'h00,
                      {32'h00000003, 32'h23456781, 32'hF0000000, 32'h80000000}, 1'b0);
        applyStimulus(OP_ROTI, 7'd11, {32'h00000002, 32'h00000001, 32'h80000000, 32'hAAAAAAAA},
                      128'd0, 7'h7F,
                      {32'h00000001, 32'h80000000, 32'h40000000, 32'h55555555}, 1'b0);
        applyStimulus(OP_SHLH, 7'd12, {4{32'h80018001}},
                      {32'h0001000F, 32'h00100000, 32'h0021000F, 32'h001F0010}, 7'h00,
                      {32'h00028000, 32'h00008001, 32'h00028000, 32'h00000000}, 1'b0);
        applyStimulus(4'hF, 7'd13, {4{32'hDEADBEEF}}, {4{32'h00000001}}, 7'h01, 128'd0, 1'b1);
        applyStimulus(4'h6, 7'd13, {4{32'h0000FFFF}}, 128'd0, 7'h02, 128'd0, 1'b1);
        repeat (6) nextCycle();

        // Stall: four ops back to back, then stall three cycles with the first in writeback.
        applyStimulus(OP_SHLI, 7'd20, {4{32'h1}}, 128'd0, 7'h01, {4{32'h00000002}}, 1'b0);
        applyStimulus(OP_SHLI, 7'd21, {4{32'h1}}, 128'd0, 7'h02, {4{32'h00000004}}, 1'b0);
        applyStimulus(OP_SHLI, 7'd22, {4{32'h1}}, 128'd0, 7'h03, {4{32'h00000008}}, 1'b0);
        applyStimulus(OP_SHLI, 7'd23, {4{32'h1}}, 128'd0, 7'h04, {4{32'h00000010}}, 1'b0);
        stall       = 1'b1;
        issue_valid = 1'b1;
        issue_op    = OP_SHL;
        issue_rt    = 7'd31;
        @(negedge clk);
        checkOutput("stall_issue_ready", {127'd0, issue_ready}, 128'd0);
        repeat (3) nextCycle();
        stall       = 1'b0;
        issue_valid = 1'b0;
        repeat (8) nextCycle();

        // Flush: three in flight plus a fourth offered in the flush cycle are all discarded.
        applyStimulus(OP_SHLI, 7'd24, {4{32'h1}}, 128'd0, 7'h01, {4{32'h2}}, 1'b0);
        applyStimulus(OP_SHLI, 7'd25, {4{32'h1}}, 128'd0, 7'h01, {4{32'h2}}, 1'b0);
        applyStimulus(OP_SHLI, 7'd26, {4{32'h1}}, 128'd0, 7'h01, {4{32'h2}}, 1'b0);
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_op    = OP_SHLI;
        issue_rt    = 7'd27;
        sb.delete();
        nextCycle();
        flush = 1'b0;
        applyStimulus(OP_ROTI, 7'd28, {4{32'h80000000}}, 128'd0, 7'h01, {4{32'h00000001}}, 1'b0);
        repeat (8) nextCycle();

        // Hazard: op with rt 9 walks through stages 1..3 then writeback; stale invalid rt 9 follows.
        applyStimulus(OP_SHL, 7'd9, {32'h0, 32'h0, 32'h0, 32'h1}, 128'd0, 7'h00,
                      {32'h0, 32'h0, 32'h0, 32'h1}, 1'b0);
        chk_a    = 7'd9;
        chk_b    = 7'd10;
        issue_rt = 7'd9;
        nextCycle();
        @(negedge clk);
        checkOutput("hz_s2_hit_a", {127'd0, hit_a}, 128'd1);
        checkOutput("hz_s2_hit_b", {127'd0, hit_b}, 128'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("hz_s3_hit_a", {127'd0, hit_a}, 128'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("hz_wb_hit_a", {127'd0, hit_a}, 128'd0);
        checkOutput("hz_wb_valid", {127'd0, wb_valid}, 128'd1);
        repeat (4) nextCycle();

        // Reset mid-stream: an illegal op would reach writeback the cycle after reset.
        chk_a = 7'd15;
        chk_b = 7'd14;
        applyStimulus(4'hF, 7'd14, {4{32'hFFFFFFFF}}, 128'd0, 7'h00, 128'd0, 1'b1);
        applyStimulus(OP_SHLI, 7'd15, {4{32'h1}}, 128'd0, 7'h01, {4{32'h2}}, 1'b0);
        nextCycle();
        reset       = 1'b1;
        issue_valid = 1'b1;
        issue_rt    = 7'd15;
        sb.delete();
        @(negedge clk);
        checkOutput("rst_mid_issue_ready", {127'd0, issue_ready}, 128'd0);
        nextCycle();
        reset       = 1'b0;
        issue_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_wb_valid", {127'd0, wb_valid}, 128'd0);
        checkOutput("rst_mid_wb_err", {127'd0, wb_err}, 128'd0);
        checkOutput("rst_mid_wb_rt", {121'd0, wb_rt}, 128'd0);
        checkOutput("rst_mid_wb_data", wb_data, 128'd0);
        checkOutput("rst_mid_hits", {126'd0, hit_a, hit_b}, 128'd0);
        applyStimulus(OP_SHLI, 7'd16, {4{32'h80000001}}, 128'd0, 7'h01, {4{32'h00000002}}, 1'b0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) nextCycle();
        checkOutput("sb_drained", sb.size(), 128'd0);
        repeat (6) nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx2_pipe_ctrl.md
FX2_PIPE_CTRL -- requirements
Module: fx2_pipe_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 4, meaning issue-to-writeback latency in cycles (fixed at 4 for this release).
REQ-002 SHALL have ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- issue_valid, in, 1: instruction offered.
- issue_ready, out, 1: instruction accepted this cycle when high with issue_valid.
- issue_op, in, 4: FX2 opcode, values from the shared package.
- issue_rt, in, 7: target register address.
- issue_ra, in, [0:127]: operand A, bit 0 MSB.
- issue_rb, in, [0:127]: operand B, shift-count source.
- issue_imm7, in, [0:6]: immediate count.
- stall, in, 1: writeback port not granted.
- flush, in, 1: kill all in-flight work.
- chk_a / chk_b, in, 7 each: register addresses checked for hazard.
- hit_a / hit_b, out, 1 each: in-flight op targets chk_a / chk_b.
- wb_valid, out, 1: writeback result valid.
- wb_rt, out, 7: writeback target register.
- wb_data, out, [0:127]: writeback result.
- wb_err, out, 1: result came from an illegal opcode.

Function
REQ-003 Ops SHALL be SHL, SHLI, ROT, ROTI, SHLH and SHLHI; every other code is illegal.
REQ-004 Each 32-bit word or 16-bit halfword SHALL be processed independently.
REQ-005 Register-form count SHALL be taken from the matching slot of rb: low 6 bits for word ops, low 5 bits for halfword ops.
REQ-006 Immediate-form count SHALL be imm7 sign-extended, then masked to 6 bits (word ops) or 5 bits (halfword ops).
REQ-007 SHL/SHLI SHALL give zero for a count of 32 or more; SHLH/SHLHI SHALL give zero for a count of 16 or more; vacated bits SHALL be 0.
REQ-008 ROT/ROTI SHALL rotate left by the count modulo 32.
REQ-009 An illegal op SHALL flow through the pipeline with wb_data = 0 and wb_err = 1.
REQ-010 issue_ready SHALL equal !stall && !reset; an op is accepted when issue_valid && issue_ready.
REQ-011 An op accepted in cycle N SHALL present wb_valid = 1 in cycle N+LAT when no stall occurs; each stall cycle adds one cycle.
REQ-012 Results SHALL be computed combinationally and registered into stage 1; stages 2..LAT only delay {valid, rt, data, err}.
REQ-013 While stall = 1, all stage registers and all wb_* outputs SHALL hold their values, and no op is accepted.
REQ-014 flush = 1 SHALL clear every stage valid and wb_valid at the next edge, and SHALL discard any op offered in that cycle.
REQ-015 flush SHALL take priority over stall.
REQ-016 wb_valid SHALL hold for a single cycle per op unless stall holds it.
REQ-017 Back-to-back issue SHALL sustain one op per cycle, with no bubbles.
REQ-018 hit_a SHALL be combinational: 1 when any valid stage 1..LAT-1 holds rt == chk_a; hit_b likewise for chk_b.
REQ-019 The writeback stage SHALL be excluded from the hazard check; the forwarding path covers it.
REQ-020 Invalid stages SHALL never assert hit_a or hit_b, whatever their stale rt.

Reset
REQ-021 On reset high at a clock edge:
- all stage valids SHALL be cleared;
- wb_valid, wb_err, hit_a and hit_b SHALL be 0;
- wb_rt SHALL be 0 and wb_data SHALL be all zeros.
REQ-022 Reset mid-operation SHALL discard all in-flight ops; the first accept after reset is permitted in the cycle reset is low.
REQ-023 Reset SHALL dominate flush and stall.

Structure
REQ-024 The opcode enumeration, LAT default and the word/halfword width constants SHALL live in shared package spu_fx2_pkg.
REQ-025 Shift/rotate arithmetic SHALL be in a combinational sub-module fx2_shift_core; fx2_pipe_ctrl holds the issue handshake, stage registers, stall/flush control and hazard compare.

Verification
REQ-026 SHLI test: ra word0 = 0x0000_0001, imm7 = 7'h04, rt = 5, issued in cycle 10 -> cycle 14: wb_valid = 1, wb_rt = 5, wb word0 = 0x0000_0010.
REQ-027 Count-boundary test:
- SHL with rb word count 32 -> word 0.
- SHLHI with imm7 = 7'h7F -> count 31 -> every halfword 0.
- ROT 0x8000_0001 by 33 -> 0x0000_0003.
REQ-028 Stall test: four ops issued back-to-back, stall high for 3 cycles once the first reaches writeback -> the first result is held 3 cycles, all four complete in order, none lost or duplicated.
REQ-029 Flush test: flush while 3 ops are in flight and a 4th is offered -> no wb_valid for any of them; an op issued the next cycle writes back 4 cycles later.
REQ-030 Hazard test: rt = 9 in stage 2, chk_a = 9, chk_b = 10 -> hit_a = 1, hit_b = 0; with the op in the writeback stage -> hit_a = 0.
REQ-031 Illegal and reset test:
- issue_op = 4'hF -> wb_data = 0, wb_err = 1.
- reset asserted mid-stream -> all outputs 0 in the next cycle.
